sha256crypt_unit_sched: RTL
===========================

// Module: sha256crypt_unit_sched
// PURPOSE
//  Scheduler between the candidate-word source (word_gen output, FWFT) and the
//  N_UNITS sha256crypt computing units. Round-robin over units that are idle,
//  not excluded and not already claimed; streams one whole candidate per grant.
//  Honours the unit-exclusion mask from config packet subtype 1 and drives
//  cores_idle toward app_status.
// PARAMETERS
//  N_UNITS    16  number of computing units (2..32)
//  MAX_WORDS  8   max 16-bit words per candidate; overrun forces termination
// PORTS
//  CORE_CLK      in   1        clock, all logic on rising edge
//  rst           in   1        synchronous, active-high reset
//  din           in   16       candidate data word (FWFT: valid while !empty)
//  din_last      in   1        din is the last word of its candidate
//  empty         in   1        source empty
//  rd_en         out  1        pop din this cycle
//  unit_mask     in   N_UNITS  1 = unit excluded (static config, sampled at grant)
//  unit_idle     in   N_UNITS  1 = unit can accept a new candidate
//  unit_din      out  16       registered broadcast data to all units
//  unit_last     out  1        registered; marks last word to the unit
//  unit_wr_en    out  N_UNITS  registered one-hot write strobe
//  cores_idle    out  1        no work pending, all enabled units idle
//  dispatch_cnt  out  32       candidates fully dispatched (saturating)
//  err_overrun   out  1        sticky: candidate exceeded MAX_WORDS
//  err_no_unit   out  1        unit_mask all ones while source non-empty
// BEHAVIOUR
//  Reset: rd_en, unit_wr_en, unit_last, err_* = 0; unit_din = 0; dispatch_cnt = 0;
//   cores_idle = 0 (for the reset cycle, then per formula); claimed = 0; rr_ptr = 0;
//   state = IDLE. Reset mid-XFER aborts the candidate; no unit_last is sent.
//  eligible = unit_idle & ~unit_mask & ~claimed.
//  FSM IDLE: if !empty && |eligible -> grant first eligible unit at or after
//   rr_ptr (wrap N_UNITS-1 -> 0). Set sel, claimed[sel], rr_ptr = sel+1 (wrapping);
//   -> XFER. There is no rd_en in the grant cycle.
//  FSM XFER: rd_en = !empty (combinational). On each pop, next cycle:
//   unit_din = din, unit_wr_en = 1<<sel, unit_last = din_last. Word counter wc
//   increments per pop. On popping din_last -> IDLE, dispatch_cnt += 1.
//   If the pop making wc == MAX_WORDS has din_last = 0: unit_last is forced to 1,
//   err_overrun is set, and state -> DRAIN.
//  FSM DRAIN: rd_en = !empty; words are discarded, so no unit_wr_en.
//   On din_last -> IDLE. dispatch_cnt does not increment.
//  Source stall mid-candidate (empty in XFER): rd_en = 0, no strobe, wait.
//  claimed[u] clears when unit_idle[u] is seen 0, or on rst. A claimed unit that
//   never drops idle stays claimed, so other units keep it from being re-granted.
//  Grant to IDLE turnaround: one cycle minimum between candidates. Peak is
//   (words+1) cycles per candidate.
//  unit_mask changes during XFER do not abort the current transfer.
//  err_no_unit = (&unit_mask) && !empty, registered, non-sticky.
//  cores_idle = state==IDLE && empty && claimed==0 && &(unit_idle|unit_mask),
//   registered.
//  dispatch_cnt saturates at 32'hFFFFFFFF.
// TESTING
//  1 N=4, all idle, mask=0, 3 candidates of 4 words -> grants to units 0,1,2;
//    each gets 4 strobes, unit_last on the 4th; dispatch_cnt=3.
//  2 mask=4'b0101, all idle, 4 candidates -> grants alternate 1,3,1,3
//    (units drop idle after 1st word and return idle after 20 cycles).
//  3 Candidate of 10 words with MAX_WORDS=8 -> 8 strobes, unit_last on the 8th,
//    err_overrun=1, 2 words drained, dispatch_cnt unchanged, next candidate normal.
//  4 empty toggled every other cycle inside a 4-word candidate -> exactly 4 strobes,
//    data in order, no strobe while empty.
//  5 rst asserted on the 2nd word of XFER -> next cycle all outputs 0, rr_ptr=0;
//    next grant goes to unit 0.
//  6 mask=4'hF with the source non-empty -> no rd_en, err_no_unit=1.
//    Clearing the mask -> grant within 2 cycles; cores_idle=1 only after the
//    source is empty and all units idle.

Source files
------------

// File: rtl/sha256crypt_unit_sched.sv
// Round-robin dispatcher from the FWFT candidate source to the sha256crypt units.
// One whole candidate is streamed to a single granted unit per grant.
module sha256crypt_unit_sched #(
  parameter int N_UNITS   = 16,
  parameter int MAX_WORDS = 8
) (
  input  logic               CORE_CLK,
  input  logic               rst,
  input  logic [15:0]        din,
  input  logic               din_last,
  input  logic               empty,
  output logic               rd_en,
  input  logic [N_UNITS-1:0] unit_mask,
  input  logic [N_UNITS-1:0] unit_idle,
  output logic [15:0]        unit_din,
  output logic               unit_last,
  output logic [N_UNITS-1:0] unit_wr_en,
  output logic               cores_idle,
  output logic [31:0]        dispatch_cnt,
  output logic               err_overrun,
  output logic               err_no_unit
);

  // state | meaning
  // IDLE  | waiting for a candidate and an eligible unit
  // XFER  | streaming words of the current candidate to unit sel
  // DRAIN | discarding the tail of an over-long candidate
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  localparam int PW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam int WW = $clog2(MAX_WORDS + 1);
  localparam logic [N_UNITS-1:0] ONE = {{(N_UNITS-1){1'b0}}, 1'b1};

  state_t state, state_nxt;
  logic [PW-1:0] sel, rr_ptr, grant_idx;
  logic [N_UNITS-1:0] claimed, eligible;
  logic [WW-1:0] wc;
  logic grant_found, grant, xfer_pop, wc_full;
  int idx;

  assign eligible = unit_idle & ~unit_mask & ~claimed;
  assign wc_full  = (wc == WW'(MAX_WORDS - 1));

  // First eligible unit at or after rr_ptr, wrapping at N_UNITS.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 0; i < N_UNITS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_UNITS) idx = idx - N_UNITS;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(idx);
      end
    end
  end

  always_ff @(posedge CORE_CLK) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    grant     = 1'b0;
    xfer_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && grant_found) begin
          grant     = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        rd_en    = !empty;
        xfer_pop = !empty;
        if (xfer_pop) begin
          if (din_last)     state_nxt = IDLE;
          else if (wc_full) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        rd_en = !empty;
        if (!empty && din_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CORE_CLK) begin
    if (rst) begin
      sel          <= '0;
      rr_ptr       <= '0;
      claimed      <= '0;
      wc           <= '0;
      unit_din     <= '0;
      unit_last    <= 1'b0;
      unit_wr_en   <= '0;
      cores_idle   <= 1'b0;
      dispatch_cnt <= '0;
      err_overrun  <= 1'b0;
      err_no_unit  <= 1'b0;
    end else begin
      // A claim is released once the unit has been seen busy.
      claimed    <= (claimed & unit_idle) | (grant ? (ONE << grant_idx) : '0);
      unit_wr_en <= '0;
      unit_last  <= 1'b0;
      if (grant) begin
        sel    <= grant_idx;
        rr_ptr <= (grant_idx == PW'(N_UNITS - 1)) ? '0 : grant_idx + PW'(1);
        wc     <= '0;
      end
      if (xfer_pop) begin
        unit_din   <= din;
        unit_wr_en <= ONE << sel;
        unit_last  <= din_last | wc_full;
        wc         <= wc + WW'(1);
        if (din_last && dispatch_cnt != 32'hFFFF_FFFF) dispatch_cnt <= dispatch_cnt + 32'd1;
        if (!din_last && wc_full) err_overrun <= 1'b1;
      end
      err_no_unit <= (&unit_mask) && !empty;
      cores_idle  <= (state == IDLE) && empty && (claimed == '0) && (&(unit_idle | unit_mask));
    end
  end

endmodule
